vga_timing_gen: RTL and testbench

- Generates raster timing for the 640x480@60 Hz VGA output: horizontal/vertical pixel counters, active-low HSYNC/VSYNC, the active-video flag, and the pixel clock for the DAC.
- DrawX, DrawY and blank drive the colour mapper. blank=1 means visible region; blank=0 means the mapper outputs black.
- frame_tick is the once-per-frame strobe used by the object-motion logic.
- Sits between the 50 MHz system clock and the colour mapper / VGA DAC pins.

---
 rtl/vga_timing_gen.sv | 145 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (640x480 at 60 Hz with the default parameters).
//
// Divides the system clock down to the pixel rate and drives the horizontal and
// vertical pixel counters. It produces active-low sync pulses, the active-video
// flag and a once-per-frame strobe. Every registered output is loaded on the
// same edge as the counters, so all outputs are cycle-aligned with DrawX and DrawY.
//
// Ports:
//   Clk         in   system clock
//   Reset_n     in   asynchronous active-low reset
//   VGA_Clk     out  pixel clock for the DAC (Clk / CLK_DIV, 50% duty)
//   pix_en      out  one-Clk strobe, high in the cycle whose closing edge advances the counters
//   hs, vs      out  horizontal / vertical sync, active low
//   blank       out  1 = visible region, 0 = blanking
//   DrawX       out  horizontal pixel count
//   DrawY       out  line count
//   frame_tick  out  one-Clk pulse when the counters enter (0, V_VISIBLE)
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  // Must be an even integer >= 2.
  parameter int unsigned CLK_DIV   = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  output logic       VGA_Clk,
  output logic       pix_en,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_tick
);

  localparam int unsigned HTotal = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int unsigned DivW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0] DivHalf = DivW'(CLK_DIV / 2);

  localparam logic [9:0] HLast      = 10'(HTotal - 1);
  localparam logic [9:0] VLast      = 10'(VTotal - 1);
  localparam logic [9:0] HVis       = 10'(H_VISIBLE);
  localparam logic [9:0] VVis       = 10'(V_VISIBLE);
  localparam logic [9:0] HSyncFirst = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HSyncLast  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VSyncFirst = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VSyncLast  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [DivW-1:0] div_cnt_d, div_cnt_q;
  logic [9:0]      hc_d, hc_q;
  logic [9:0]      vc_d, vc_q;
  logic            vga_clk_d, vga_clk_q;
  logic            pix_en_d, pix_en_q;
  logic            hs_d, hs_q;
  logic            vs_d, vs_q;
  logic            blank_d, blank_q;
  logic            frame_tick_d, frame_tick_q;
  logic            advance;

  always_comb begin
    div_cnt_d    = div_cnt_q;
    hc_d         = hc_q;
    vc_d         = vc_q;
    hs_d         = hs_q;
    vs_d         = vs_q;
    blank_d      = blank_q;
    frame_tick_d = 1'b0;

    advance = (div_cnt_q == DivLast);

    if (advance) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end

    if (advance) begin
      if (hc_q == HLast) begin
        hc_d = '0;
        if (vc_q == VLast) begin
          vc_d = '0;
        end else begin
          vc_d = vc_q + 1'b1;
        end
      end else begin
        hc_d = hc_q + 1'b1;
      end

      // Decode from the next-state counters so the registered flags line up
      // with DrawX/DrawY rather than trailing them by a pixel.
      hs_d         = ~((hc_d >= HSyncFirst) && (hc_d <= HSyncLast));
      vs_d         = ~((vc_d >= VSyncFirst) && (vc_d <= VSyncLast));
      blank_d      = (hc_d < HVis) && (vc_d < VVis);
      frame_tick_d = (hc_d == '0) && (vc_d == VVis);
    end

    // Registered copies of the divider decodes keep VGA_Clk glitch-free.
    pix_en_d  = (div_cnt_d == DivLast);
    vga_clk_d = (div_cnt_d >= DivHalf);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_cnt_q    <= '0;
      hc_q         <= '0;
      vc_q         <= '0;
      vga_clk_q    <= 1'b0;
      pix_en_q     <= 1'b0;
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
      // Held low in reset even though (0,0) is visible; set on the first advance.
      blank_q      <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      hc_q         <= hc_d;
      vc_q         <= vc_d;
      vga_clk_q    <= vga_clk_d;
      pix_en_q     <= pix_en_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      blank_q      <= blank_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign VGA_Clk    = vga_clk_q;
  assign pix_en     = pix_en_q;
  assign hs         = hs_q;
  assign vs         = vs_q;
  assign blank      = blank_q;
  assign DrawX      = hc_q;
  assign DrawY      = vc_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances share one clock.
//   0: default 640x480 geometry, CLK_DIV=2
//   1: small 16x6 geometry (25x13 total), CLK_DIV=2, used for frame-level and reset tests
//   2: default geometry, CLK_DIV=4
// A closed-form model (position derived from edges since reset) feeds per-instance
// scoreboard queues. A constant table spot-checks key raster points.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       vga_clk;
    logic       pix_en;
    logic       hs;
    logic       vs;
    logic       blank;
    logic [9:0] x;
    logic [9:0] y;
    logic       ft;
  } obs_t;

  typedef struct {
    int d, hv, hf, hsw, hb, vv, vf, vsw, vb;
  } geom_t;

  typedef struct {
    int   inst;
    int   t;
    obs_t exp;
  } vec_t;

  logic Clk = 1'b0;
  logic rst_n [3];

  logic       vga_clk [3];
  logic       pix_en  [3];
  logic       hs      [3];
  logic       vs      [3];
  logic       blank   [3];
  logic [9:0] draw_x  [3];
  logic [9:0] draw_y  [3];
  logic       ft      [3];

  geom_t geo [3];
  int    tcnt [3];
  obs_t  sbq [3][$];
  vec_t  vecs [$];
  int    checks = 0;
  int    errors = 0;

  always #5 Clk = ~Clk;

  vga_timing_gen u_full (
    .Clk(Clk), .Reset_n(rst_n[0]), .VGA_Clk(vga_clk[0]), .pix_en(pix_en[0]), .hs(hs[0]),
    .vs(vs[0]), .blank(blank[0]), .DrawX(draw_x[0]), .DrawY(draw_y[0]), .frame_tick(ft[0])
  );

  vga_timing_gen #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .CLK_DIV(2)
  ) u_small (
    .Clk(Clk), .Reset_n(rst_n[1]), .VGA_Clk(vga_clk[1]), .pix_en(pix_en[1]), .hs(hs[1]),
    .vs(vs[1]), .blank(blank[1]), .DrawX(draw_x[1]), .DrawY(draw_y[1]), .frame_tick(ft[1])
  );

  vga_timing_gen #(.CLK_DIV(4)) u_div4 (
    .Clk(Clk), .Reset_n(rst_n[2]), .VGA_Clk(vga_clk[2]), .pix_en(pix_en[2]), .hs(hs[2]),
    .vs(vs[2]), .blank(blank[2]), .DrawX(draw_x[2]), .DrawY(draw_y[2]), .frame_tick(ft[2])
  );

  // Expected outputs after t rising edges out of reset (t=0 is the reset state).
  function automatic obs_t model(input int i, input int t);
    obs_t  o;
    geom_t g  = geo[i];
    int    ht = g.hv + g.hf + g.hsw + g.hb;
    int    vt = g.vv + g.vf + g.vsw + g.vb;
    int    p  = t / g.d;
    int    dv = t % g.d;
    int    x  = p % ht;
    int    y  = (p / ht) % vt;
    o.vga_clk = (dv >= g.d / 2);
    o.pix_en  = (dv == g.d - 1);
    o.hs      = !((x >= g.hv + g.hf) && (x < g.hv + g.hf + g.hsw));
    o.vs      = !((y >= g.vv + g.vf) && (y < g.vv + g.vf + g.vsw));
    o.blank   = (p > 0) && (x < g.hv) && (y < g.vv);
    o.ft      = (t > 0) && (dv == 0) && (x == 0) && (y == g.vv);
    o.x       = 10'(x);
    o.y       = 10'(y);
    return o;
  endfunction

  function automatic obs_t sample(input int i);
    obs_t o;
    o = '{vga_clk[i], pix_en[i], hs[i], vs[i], blank[i], draw_x[i], draw_y[i], ft[i]};
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual vclk=%b pix=%b hs=%b vs=%b blank=%b x=%0d y=%0d ft=%b required vclk=%b pix=%b hs=%b vs=%b blank=%b x=%0d y=%0d ft=%b",
               name, act.vga_clk, act.pix_en, act.hs, act.vs, act.blank, act.x, act.y, act.ft,
               exp.vga_clk, exp.pix_en, exp.hs, exp.vs, exp.blank, exp.x, exp.y, exp.ft);
    end
  endtask

  // One Clk: push the expectation at the rising edge, compare at the falling edge.
  task automatic step();
    obs_t e;
    @(posedge Clk);
    for (int i = 0; i < 3; i++) begin
      if (rst_n[i]) tcnt[i]++;
      sbq[i].push_back(model(i, tcnt[i]));
    end
    @(negedge Clk);
    for (int i = 0; i < 3; i++) begin
      e = sbq[i].pop_front();
      check($sformatf("sb%0d_t%0d", i, tcnt[i]), sample(i), e);
    end
  endtask

  task automatic add(input int inst, input int t, input int x, input int y, input bit h,
                     input bit v, input bit b, input bit pe, input bit vc, input bit f);
    vec_t r;
    r.inst = inst;
    r.t    = t;
    r.exp  = '{vc, pe, h, v, b, 10'(x), 10'(y), f};
    vecs.push_back(r);
  endtask

  initial begin
    obs_t s;
    int   n;
    bit   seen;

    geo[0] = '{2, 640, 16, 96, 48, 480, 10, 2, 33};
    geo[1] = '{2, 16, 2, 4, 3, 6, 2, 2, 3};
    geo[2] = '{4, 640, 16, 96, 48, 480, 10, 2, 33};

    //   inst t     x    y  hs vs bl pe vc ft   (sorted by t)
    add(0,    1,    0,  0, 1, 1, 0, 1, 1, 0);
    add(2,    1,    0,  0, 1, 1, 0, 0, 0, 0);
    add(0,    2,    1,  0, 1, 1, 1, 0, 0, 0);
    add(2,    2,    0,  0, 1, 1, 0, 0, 1, 0);
    add(2,    3,    0,  0, 1, 1, 0, 1, 1, 0);
    add(2,    4,    1,  0, 1, 1, 1, 0, 0, 0);
    add(1,   30,   15,  0, 1, 1, 1, 0, 0, 0);
    add(1,   32,   16,  0, 1, 1, 0, 0, 0, 0);
    add(1,   36,   18,  0, 0, 1, 0, 0, 0, 0);
    add(1,  300,    0,  6, 1, 1, 0, 0, 0, 1);
    add(1,  301,    0,  6, 1, 1, 0, 1, 1, 0);
    add(1,  400,    0,  8, 1, 0, 0, 0, 0, 0);
    add(1,  650,    0,  0, 1, 1, 1, 0, 0, 0);
    add(0, 1278,  639,  0, 1, 1, 1, 0, 0, 0);
    add(0, 1280,  640,  0, 1, 1, 0, 0, 0, 0);
    add(0, 1310,  655,  0, 1, 1, 0, 0, 0, 0);
    add(0, 1312,  656,  0, 0, 1, 0, 0, 0, 0);
    add(0, 1313,  656,  0, 0, 1, 0, 1, 1, 0);
    add(0, 1502,  751,  0, 0, 1, 0, 0, 0, 0);
    add(0, 1504,  752,  0, 1, 1, 0, 0, 0, 0);
    add(0, 1598,  799,  0, 1, 1, 0, 0, 0, 0);
    add(0, 1600,    0,  1, 1, 1, 1, 0, 0, 0);
    add(2, 2624,  656,  0, 0, 1, 0, 0, 0, 0);
    add(2, 3008,  752,  0, 1, 1, 0, 0, 0, 0);
    add(2, 3200,    0,  1, 1, 1, 1, 0, 0, 0);

    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0;
      tcnt[i]  = 0;
    end
    repeat (3) step();
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

    foreach (vecs[k]) begin
      n = 0;
      while (tcnt[vecs[k].inst] < vecs[k].t && n < 5000) begin
        step();
        n++;
      end
      check($sformatf("vec%0d_i%0d_t%0d", k, vecs[k].inst, vecs[k].t),
            sample(vecs[k].inst), vecs[k].exp);
    end

    // Reset the small instance while its vertical sync is active.
    n = 0;
    s = sample(1);
    while (s.y != 10'd8 && n < 700) begin
      step();
      n++;
      s = sample(1);
    end
    checks++;
    if (s.y != 10'd8 || s.vs !== 1'b0) begin
      errors++;
      $display("FAIL wait_vsync actual y=%0d vs=%b required y=8 vs=0", s.y, s.vs);
    end
    rst_n[1] = 1'b0;
    #1;
    check("async_reset", sample(1), model(1, 0));
    tcnt[1] = 0;
    repeat (3) step();
    rst_n[1] = 1'b1;

    // First frame_tick after release comes 6 lines in; then one full frame apart.
    for (int r = 0; r < 2; r++) begin
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 1000) begin
        step();
        n++;
        s = sample(1);
        if (s.ft) seen = 1'b1;
      end
      checks++;
      if (!seen || n != ((r == 0) ? 300 : 650)) begin
        errors++;
        $display("FAIL frame_tick_gap%0d actual seen=%b clks=%0d required seen=1 clks=%0d",
                 r, seen, n, (r == 0) ? 300 : 650);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
